// File: rtl/operand_fetch.sv
// operand_fetch: issue stage in front of the register file.
// Takes decoded instructions over valid/ready and drives the register file
// read addresses. Same-cycle writeback data is bypassed into the operands.
// A busy-bit scoreboard stalls RAW/WAW hazards. Fetched operands are held in
// a one-entry output stage for execute.
module operand_fetch #(
    parameter int N = 32,
    parameter int R = 7
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         inValid,
    output logic         inReady,
    input  logic [R-1:0] inRs1,
    input  logic [R-1:0] inRs2,
    input  logic [R-1:0] inRd,
    input  logic [N-1:0] inImm,
    input  logic         inRegWrite,
    output logic [R-1:0] readReg1,
    output logic [R-1:0] readReg2,
    input  logic [N-1:0] readData1,
    input  logic [N-1:0] readData2,
    input  logic         wbEnable,
    input  logic [R-1:0] wbReg,
    input  logic [N-1:0] wbData,
    input  logic         flush,
    output logic         outValid,
    input  logic         outReady,
    output logic [N-1:0] outRs1Data,
    output logic [N-1:0] outRs2Data,
    output logic [R-1:0] outRd,
    output logic [N-1:0] outImm,
    output logic         outRegWrite,
    output logic [15:0]  stallCount
);

    localparam int NREG = 1 << R;

    logic [NREG-1:0] r_busy;
    logic            r_out_valid;
    logic [N-1:0]    r_rs1_data;
    logic [N-1:0]    r_rs2_data;
    logic [R-1:0]    r_rd;
    logic [N-1:0]    r_imm;
    logic            r_reg_write;
    logic [15:0]     r_stall_count;

    logic            w_wb_hit1;
    logic            w_wb_hit2;
    logic            w_wb_hitd;
    logic            w_hazard;
    logic            w_accept;
    logic [N-1:0]    w_op1;
    logic [N-1:0]    w_op2;

    assign readReg1 = inRs1;
    assign readReg2 = inRs2;

    // A writeback to a busy source resolves the hazard in the same cycle,
    // because its data is bypassed instead of read from the stale file.
    always_comb begin
        w_wb_hit1 = wbEnable && (wbReg == inRs1);
        w_wb_hit2 = wbEnable && (wbReg == inRs2);
        w_wb_hitd = wbEnable && (wbReg == inRd);
        w_hazard  = (r_busy[inRs1] && !w_wb_hit1)
                 || (r_busy[inRs2] && !w_wb_hit2)
                 || (inRegWrite && r_busy[inRd] && !w_wb_hitd);
        w_op1     = w_wb_hit1 ? wbData : readData1;
        w_op2     = w_wb_hit2 ? wbData : readData2;
        inReady   = resetN && !flush && !w_hazard && (!r_out_valid || outReady);
        w_accept  = inValid && inReady;
    end

    // One-entry output stage; data registers only change on accept.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_out_valid <= 1'b0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_rd        <= '0;
            r_imm       <= '0;
            r_reg_write <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_rs1_data  <= w_op1;
            r_rs2_data  <= w_op2;
            r_rd        <= inRd;
            r_imm       <= inImm;
            r_reg_write <= inRegWrite;
        end else if (outReady) begin
            r_out_valid <= 1'b0;
        end
    end

    // Scoreboard: the set is written after the clear so it wins on a collision.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_busy <= '0;
        end else if (flush) begin
            r_busy <= '0;
        end else begin
            if (wbEnable) begin
                r_busy[wbReg] <= 1'b0;
            end
            if (w_accept && inRegWrite) begin
                r_busy[inRd] <= 1'b1;
            end
        end
    end

    // Saturating count of cycles an offered instruction was held by a hazard.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_stall_count <= '0;
        end else if (inValid && w_hazard && !flush && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign outValid    = r_out_valid;
    assign outRs1Data  = r_rs1_data;
    assign outRs2Data  = r_rs2_data;
    assign outRd       = r_rd;
    assign outImm      = r_imm;
    assign outRegWrite = r_reg_write;
    assign stallCount  = r_stall_count;

endmodule

// File: tb/tb_operand_fetch.sv
// Testbench for operand_fetch: directed test-plan steps followed by random
// traffic, all checked against a scoreboard/register-file model in the bench.
module tb_operand_fetch;
    localparam int N = 32;
    localparam int R = 7;

    logic         clk = 1'b0;
    logic         resetN;
    logic         inValid;
    logic         inReady;
    logic [R-1:0] inRs1, inRs2, inRd;
    logic [N-1:0] inImm;
    logic         inRegWrite;
    logic [R-1:0] readReg1, readReg2;
    logic [N-1:0] readData1, readData2;
    logic         wbEnable;
    logic [R-1:0] wbReg;
    logic [N-1:0] wbData;
    logic         flush;
    logic         outValid;
    logic         outReady;
    logic [N-1:0] outRs1Data, outRs2Data;
    logic [R-1:0] outRd;
    logic [N-1:0] outImm;
    logic         outRegWrite;
    logic [15:0]  stallCount;

    always #5 clk = ~clk;

    operand_fetch #(.N(N), .R(R)) dut (
        .clk(clk), .resetN(resetN),
        .inValid(inValid), .inReady(inReady),
        .inRs1(inRs1), .inRs2(inRs2), .inRd(inRd), .inImm(inImm), .inRegWrite(inRegWrite),
        .readReg1(readReg1), .readReg2(readReg2),
        .readData1(readData1), .readData2(readData2),
        .wbEnable(wbEnable), .wbReg(wbReg), .wbData(wbData),
        .flush(flush),
        .outValid(outValid), .outReady(outReady),
        .outRs1Data(outRs1Data), .outRs2Data(outRs2Data),
        .outRd(outRd), .outImm(outImm), .outRegWrite(outRegWrite),
        .stallCount(stallCount)
    );

    // Register file model, read combinationally through the DUT's read ports.
    logic [N-1:0] rf [0:127];
    assign readData1 = rf[readReg1];
    assign readData2 = rf[readReg2];

    // Reference state
    bit           m_busy [0:127];
    bit           m_ov;
    logic [N-1:0] m_d1, m_d2, m_imm;
    logic [R-1:0] m_rd;
    bit           m_rw;
    int           m_stall;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) m_busy[i] = 1'b0;
        m_ov = 1'b0; m_d1 = '0; m_d2 = '0; m_imm = '0; m_rd = '0; m_rw = 1'b0; m_stall = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".outValid"},    {31'd0, outValid},    {31'd0, m_ov});
        chk({tag, ".outRs1Data"},  outRs1Data,           m_d1);
        chk({tag, ".outRs2Data"},  outRs2Data,           m_d2);
        chk({tag, ".outRd"},       {25'd0, outRd},       {25'd0, m_rd});
        chk({tag, ".outImm"},      outImm,               m_imm);
        chk({tag, ".outRegWrite"}, {31'd0, outRegWrite}, {31'd0, m_rw});
        chk({tag, ".stallCount"},  {16'd0, stallCount},  m_stall);
    endtask

    // One clock cycle with the inputs already driven (called just after negedge).
    task automatic step(input string tag, input bit do_chk);
        bit hit1, hit2, hitd, hazard, exp_ready, acc;
        logic [N-1:0] op1, op2;
        #1;
        hit1   = wbEnable && (wbReg == inRs1);
        hit2   = wbEnable && (wbReg == inRs2);
        hitd   = wbEnable && (wbReg == inRd);
        hazard = (m_busy[inRs1] && !hit1) || (m_busy[inRs2] && !hit2)
              || (inRegWrite && m_busy[inRd] && !hitd);
        exp_ready = !flush && !hazard && (!m_ov || outReady);
        acc = inValid && exp_ready;
        if (do_chk) begin
            chk({tag, ".inReady"},  {31'd0, inReady},  {31'd0, exp_ready});
            chk({tag, ".readReg1"}, {25'd0, readReg1}, {25'd0, inRs1});
            chk({tag, ".readReg2"}, {25'd0, readReg2}, {25'd0, inRs2});
        end
        op1 = hit1 ? wbData : rf[inRs1];
        op2 = hit2 ? wbData : rf[inRs2];
        @(posedge clk);
        #1;
        if (inValid && hazard && !flush && m_stall < 16'hFFFF) m_stall++;
        if (flush) begin
            m_ov = 1'b0;
            for (int i = 0; i < 128; i++) m_busy[i] = 1'b0;
        end else begin
            if (acc) begin
                m_ov = 1'b1; m_d1 = op1; m_d2 = op2; m_rd = inRd; m_imm = inImm; m_rw = inRegWrite;
            end else if (outReady) begin
                m_ov = 1'b0;
            end
            if (wbEnable) m_busy[wbReg] = 1'b0;
            if (acc && inRegWrite) m_busy[inRd] = 1'b1;
        end
        if (wbEnable) rf[wbReg] = wbData;
        if (do_chk) check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                         input bit rw, input logic [N-1:0] imm);
        inValid = v; inRs1 = rs1[R-1:0]; inRs2 = rs2[R-1:0]; inRd = rd[R-1:0];
        inRegWrite = rw; inImm = imm;
    endtask

    task automatic wb(input bit en, input int reg_n, input logic [N-1:0] data);
        wbEnable = en; wbReg = reg_n[R-1:0]; wbData = data;
    endtask

    initial begin
        resetN = 1'b0; flush = 1'b0; outReady = 1'b1;
        drive(1'b0, 0, 0, 0, 1'b0, '0);
        wb(1'b0, 0, '0);
        for (int i = 0; i < 128; i++) rf[i] = $urandom;
        rf[5] = 32'h11; rf[6] = 32'h22;
        model_reset();

        // Reset state
        #3;
        chk("reset.inReady", {31'd0, inReady}, 32'd0);
        check_outputs("reset");
        repeat (2) @(negedge clk);
        resetN = 1'b1;

        // Simple issue
        drive(1'b1, 5, 6, 9, 1'b1, 32'hA5A5_0001);
        step("issue", 1'b1);
        chk("issue.rs1", outRs1Data, 32'h11);
        chk("issue.rs2", outRs2Data, 32'h22);
        chk("issue.rd", {25'd0, outRd}, 32'd9);

        // Bypass of stale register 5
        drive(1'b1, 5, 6, 10, 1'b1, 32'h2);
        wb(1'b1, 5, 32'hDEAD);
        step("bypass", 1'b1);
        chk("bypass.rs1", outRs1Data, 32'hDEAD);
        wb(1'b0, 0, '0);

        // RAW stall on r9 for three cycles, then writeback releases it
        drive(1'b1, 9, 6, 11, 1'b0, 32'h3);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("raw.inReady", {31'd0, inReady}, 32'd0);
            #0;
            step("raw", 1'b1);
        end
        chk("raw.stallCount", {16'd0, stallCount}, 32'd3);
        wb(1'b1, 9, 32'h77);
        step("raw_release", 1'b1);
        chk("raw_release.rs1", outRs1Data, 32'h77);
        chk("raw_release.valid", {31'd0, outValid}, 32'd1);
        wb(1'b0, 0, '0);

        // Backpressure: output held, stall count frozen
        outReady = 1'b0;
        drive(1'b1, 1, 2, 12, 1'b1, 32'h4);
        for (int k = 0; k < 4; k++) step("bp", 1'b1);
        chk("bp.rs1_hold", outRs1Data, 32'h77);
        chk("bp.stall_hold", {16'd0, stallCount}, 32'd3);
        outReady = 1'b1;
        step("bp_release", 1'b1);
        chk("bp_release.rd", {25'd0, outRd}, 32'd12);

        // Set/clear collision on r9, then flush
        drive(1'b1, 1, 2, 9, 1'b1, 32'h5);
        wb(1'b1, 9, 32'h99);
        step("collide", 1'b1);
        wb(1'b0, 0, '0);
        drive(1'b0, 9, 0, 0, 1'b0, 32'h0);
        #1;
        chk("collide.busy9", {31'd0, inReady}, 32'd0);
        flush = 1'b1;
        drive(1'b1, 9, 0, 0, 1'b0, 32'h0);
        step("flush", 1'b1);
        flush = 1'b0;
        chk("flush.valid", {31'd0, outValid}, 32'd0);
        drive(1'b0, 9, 12, 10, 1'b1, 32'h0);
        #1;
        chk("flush.busy_clear", {31'd0, inReady}, 32'd1);

        // Random traffic over a small register range to provoke hazards
        for (int t = 0; t < 400; t++) begin
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 1) == 1, $urandom);
            wb($urandom_range(0, 9) < 4, $urandom_range(0, 7), $urandom);
            flush    = ($urandom_range(0, 19) == 0);
            outReady = ($urandom_range(0, 9) < 7);
            step("rand", 1'b1);
        end
        flush = 1'b0; outReady = 1'b1; wb(1'b0, 0, '0);

        // Saturation of the stall counter
        flush = 1'b1; drive(1'b0, 0, 0, 0, 1'b0, '0);
        step("sat_flush", 1'b1);
        flush = 1'b0;
        drive(1'b1, 0, 0, 3, 1'b1, 32'h6);
        step("sat_issue", 1'b1);
        drive(1'b1, 3, 0, 4, 1'b0, 32'h7);
        for (int k = 0; k < 65540; k++) step("sat", 1'b0);
        check_outputs("sat");
        chk("sat.value", {16'd0, stallCount}, 32'hFFFF);

        // Async reset mid-stream while a bundle is presented
        wb(1'b1, 3, 32'h1234);
        step("pre_reset", 1'b1);
        chk("pre_reset.valid", {31'd0, outValid}, 32'd1);
        wb(1'b0, 0, '0);
        #2;
        resetN = 1'b0;
        #1;
        model_reset();
        chk("async.inReady", {31'd0, inReady}, 32'd0);
        check_outputs("async");
        @(negedge clk);
        resetN = 1'b1;
        drive(1'b1, 5, 6, 9, 1'b1, 32'h8);
        step("post_reset", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Issue stage directly upstream of the register file. It accepts decoded instructions over a valid/ready handshake and drives the register file read addresses. It bypasses same-cycle writeback data, tracks pending destination writes in a busy-bit scoreboard to stall on RAW/WAW hazards, and registers the fetched operands into a one-entry output stage for the execute stage.

## Interface
- n, 32, data width (matches register file)
- r, 7, register address width; scoreboard holds 2^r busy bits
- clk  input  1  rising-edge clock
- resetN  input  1  asynchronous, active-low reset
- inValid  input  1  upstream instruction valid
- inReady  output  1  upstream instruction accepted when inValid && inReady
- inRs1, inRs2, inRd  input  r  source/destination register numbers
- inImm  input  n  immediate, passed through
- inRegWrite  input  1  instruction writes inRd
- readReg1, readReg2  output  r  to register file; combinational copies of inRs1/inRs2
- readData1, readData2  input  n  from register file (combinational read)
- wbEnable, wbReg, wbData  input  1/r/n  writeback port, same signals driving the register file write port
- flush  input  1  kill output stage and clear scoreboard
- outValid  output  1  operand bundle valid
- outReady  input  1  downstream accepts bundle when outValid && outReady
- outRs1Data, outRs2Data  output  n  operand values
- outRd  output  r; outImm  output  n; outRegWrite  output  1  passed through
- stallCount  output  16  saturating count of hazard-stall cycles

## Operation
- Bypass: opX = (wbEnable && wbReg == inRsX) ? wbData : readDataX. Required because the register file commits on the clock edge.
- wbHitX = wbEnable && wbReg == inRsX; wbHitD = wbEnable && wbReg == inRd.
- Hazard = (busy[inRs1] && !wbHit1) || (busy[inRs2] && !wbHit2) || (inRegWrite && busy[inRd] && !wbHitD).
- Register 0 is not special; every register is tracked.
- inReady = resetN && !flush && !hazard && (!outValid || outReady).
- Accept = inValid && inReady.
- On accept: output registers load op1, op2, inRd, inImm, inRegWrite; outValid <= 1.
- Else if outReady: outValid <= 0. Data registers hold when not loading.
- Scoreboard clear: busy[wbReg] <= 0 when wbEnable.
- Scoreboard set: busy[inRd] <= 1 on accept with inRegWrite. Set wins over a same-cycle clear of the same register.
- Flush: outValid <= 0 and all busy bits <= 0. Flush overrides accept, set and clear. Downstream is required to discard its in-flight writes on the same cycle.
- stallCount increments by 1 on each cycle where inValid && hazard && !flush. It saturates at 16'hFFFF.

## Timing
- Reset (resetN low, asynchronous): outValid=0, outRs1Data=outRs2Data=outImm=0, outRd=0, outRegWrite=0, all busy=0, stallCount=0.
- inReady is low while resetN is low. Reset asserted mid-transfer drops the bundle with no partial state.
- readReg1/readReg2 are combinational from inRs1/inRs2, with zero cycles of latency.
- Latency is 1 cycle: a bundle accepted at edge k is presented with outValid=1 after edge k.
- Throughput is 1 per cycle when outReady stays high and there is no hazard.
- The output holds stable while outValid && !outReady. inReady stays low throughout.
- Back-to-back dependency: an instruction reading the rd of the previous accepted instruction stalls until wbEnable for that rd. It may issue in the same cycle as the writeback, taking bypassed data.
- A writeback to a register that is not busy is legal and only affects the bypass.
- inReady is combinational from the inputs and state; no combinational path runs from outReady to outValid.

## Test plan
- Reset then simple issue: the register file holds R5=0x11, R6=0x22. Issue rs1=5, rs2=6, rd=9. Required: outValid one cycle later, outRs1Data=0x11, outRs2Data=0x22, outRd=9, busy[9]=1.
- Bypass: wbEnable=1, wbReg=5, wbData=0xDEAD in the same cycle as an issue with rs1=5. Required: outRs1Data=0xDEAD, not the stale register file value.
- RAW stall: issue rd=9, then rs1=9 with no writeback for 3 cycles. Required: inReady=0 for 3 cycles and stallCount=3. When wbReg=9 with wbData=0x77 arrives, the instruction is accepted that cycle with outRs1Data=0x77.
- Backpressure: outReady=0 for 4 cycles while inValid=1. Required: outputs hold stable, inReady=0 and stallCount unchanged. On release, the next bundle follows after 1 cycle.
- Set/clear collision: wbReg=9 and an accepted issue with rd=9, inRegWrite=1, in the same cycle. Required: busy[9]=1 afterward. Flush on the next cycle gives outValid=0 and busy[9]=0.
- Async reset mid-stream: drop resetN between edges while outValid=1. Required: outValid=0 and stallCount=0 immediately, without waiting for a clock edge.
